experiment1_nios2_qsys_0_oci_dct_packer: RTL

Writer side of the OCI debug-trace frame interface. Accepts a stream of 2-bit trace atoms from the CPU trace logic and packs up to 15 into a 30-bit frame. Presents each frame as `dct_buffer`/`dct_count` to the OCI trace consumer, the test bench in simulation. Also drives the end-of-test handshake: on `test_ending` it drains the partial frame, then asserts `test_has_ended`.

---
 rtl/experiment1_nios2_qsys_0_oci_dct_packer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/experiment1_nios2_qsys_0_oci_dct_packer.sv
// -----------------------------------------------------------------------------
// experiment1_nios2_qsys_0_oci_dct_packer
//
// Writer side of the OCI debug-trace frame interface. Packs a stream of 2-bit
// trace atoms into 30-bit frames of up to 15 atoms. The newest atom sits in
// bits [1:0]. Each frame is handed to the trace consumer through a
// valid/ready handshake. On test_ending the partial frame is drained, and then
// test_has_ended is raised and held until reset.
//
// Ports
//   clk            : clock, all logic on the rising edge
//   reset          : synchronous, active-high reset
//   atom_valid     : atom is presented this cycle
//   atom[1:0]      : trace atom payload
//   atom_ready     : packer takes atom this cycle (transfer = valid && ready)
//   flush          : single-cycle request to emit the current partial frame
//   test_ending    : level, starts the end-of-test drain
//   frame_ready    : consumer takes the presented frame this cycle
//   frame_valid    : dct_buffer/dct_count hold a valid frame
//   dct_buffer     : packed atoms, newest in [1:0], unused upper bits zero
//   dct_count      : number of atoms in the frame (1..15), 0 when idle
//   test_has_ended : sticky, drain complete
//   drop_count     : saturating count of atoms dropped while stalled
//
// Build option
//   OCI_DCT_OVERFLOW_EN : when defined, atoms offered in RUN while
//                         atom_ready is low are dropped and counted in
//                         drop_count. When undefined, drop_count is tied
//                         to 0 and the source must honour atom_ready.
// -----------------------------------------------------------------------------
module experiment1_nios2_qsys_0_oci_dct_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        atom_valid,
    input  logic [1:0]  atom,
    output logic        atom_ready,
    input  logic        flush,
    input  logic        test_ending,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        test_has_ended,
    output logic [7:0]  drop_count
);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StEnded
    } state_e;

    state_e      state_q, state_d;

    // Accumulator for the frame being built
    logic [29:0] acc_buf_q, acc_buf_d;
    logic [3:0]  acc_cnt_q, acc_cnt_d;
    logic        flush_pend_q, flush_pend_d;

    // Output frame register
    logic        frame_valid_q, frame_valid_d;
    logic [29:0] dct_buffer_q, dct_buffer_d;
    logic [3:0]  dct_count_q, dct_count_d;

    logic        ended_q, ended_d;

    logic        acc_full;
    logic        acc_empty;
    logic        out_free;
    logic        flush_eff;
    logic        emit;
    logic        accept;

    // -------------------------------------------------------------------------
    // Handshake and emit decision
    // -------------------------------------------------------------------------
    always_comb begin
        acc_full   = (acc_cnt_q == 4'd15);
        acc_empty  = (acc_cnt_q == 4'd0);
        out_free   = !frame_valid_q || frame_ready;
        // DRAIN behaves as a permanently pending flush
        flush_eff  = flush_pend_q || (state_q == StDrain);
        emit       = out_free && (acc_full || (flush_eff && !acc_empty));
        // A full accumulator can still take an atom when it is emptied this cycle
        atom_ready = (state_q == StRun) && (!acc_full || emit);
        accept     = atom_valid && atom_ready;
    end

    // -------------------------------------------------------------------------
    // Accumulator next state
    // -------------------------------------------------------------------------
    always_comb begin
        acc_buf_d = acc_buf_q;
        acc_cnt_d = acc_cnt_q;
        if (emit) begin
            // Restart from zero so unused upper bits of later frames stay clear
            acc_buf_d = 30'd0;
            acc_cnt_d = 4'd0;
            if (accept) begin
                acc_buf_d = {28'd0, atom};
                acc_cnt_d = 4'd1;
            end
        end else if (accept) begin
            acc_buf_d = {acc_buf_q[27:0], atom};
            acc_cnt_d = acc_cnt_q + 4'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Pending flush
    // -------------------------------------------------------------------------
    always_comb begin
        flush_pend_d = flush_pend_q;
        if (state_q == StDrain) begin
            flush_pend_d = 1'b1;
        end else if (flush && accept) begin
            // The atom accepted alongside the flush belongs to the flushed frame,
            // even when an emit restarts the accumulator with it this cycle
            flush_pend_d = 1'b1;
        end else if (emit || (acc_empty && !accept)) begin
            flush_pend_d = 1'b0;
        end else if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output frame register next state
    // -------------------------------------------------------------------------
    always_comb begin
        frame_valid_d = frame_valid_q;
        dct_buffer_d  = dct_buffer_q;
        dct_count_d   = dct_count_q;
        if (emit) begin
            frame_valid_d = 1'b1;
            dct_buffer_d  = acc_buf_q;
            dct_count_d   = acc_cnt_q;
        end else if (frame_ready) begin
            frame_valid_d = 1'b0;
            dct_count_d   = 4'd0;
        end
    end

    // -------------------------------------------------------------------------
    // End-of-test state machine
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (test_ending) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Done once nothing is accumulated and the last frame has left
                if (acc_empty && (!frame_valid_q || (frame_ready && !emit))) begin
                    state_d = StEnded;
                end
            end
            StEnded: begin
                state_d = StEnded;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // test_has_ended follows one cycle after the machine reaches ENDED
    always_comb begin
        ended_d = (state_q == StEnded);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StRun;
            acc_buf_q     <= 30'd0;
            acc_cnt_q     <= 4'd0;
            flush_pend_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            dct_buffer_q  <= 30'd0;
            dct_count_q   <= 4'd0;
            ended_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_buf_q     <= acc_buf_d;
            acc_cnt_q     <= acc_cnt_d;
            flush_pend_q  <= flush_pend_d;
            frame_valid_q <= frame_valid_d;
            dct_buffer_q  <= dct_buffer_d;
            dct_count_q   <= dct_count_d;
            ended_q       <= ended_d;
        end
    end

    assign frame_valid    = frame_valid_q;
    assign dct_buffer     = dct_buffer_q;
    assign dct_count      = dct_count_q;
    assign test_has_ended = ended_q;

    // -------------------------------------------------------------------------
    // Drop accounting
    // -------------------------------------------------------------------------
`ifdef OCI_DCT_OVERFLOW_EN
    logic [7:0] drop_q, drop_d;
    logic       drop;

    always_comb begin
        // Only RUN counts; atoms offered while draining or ended are ignored
        drop   = (state_q == StRun) && atom_valid && !atom_ready;
        drop_d = drop_q;
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 8'd0;
`endif

endmodule
